// File: rtl/pda_trace_capture_if.sv
// Host-side word stream of the PDA trace capture block.
// The master drives one record word per handshake; the slave returns out_ready.
// Backpressure: the master holds every out_* field steady while out_ready is low.
interface pda_trace_capture_if;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pda_trace_capture.sv
// Captures one PDA stage-word record per run cycle into a FIFO and streams it word by word.
// Latency: a record pushed into an empty FIFO is presented one edge later; peak 1 word/clk.
// Backpressure: out_ready low holds the word; a full FIFO drops records. TRACE_TIMESTAMP_EN adds a cycle stamp.
module pda_trace_capture #(
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_en,
    input  logic [31:0]            inst,
    input  logic [31:0]            deco_visu,
    input  logic [31:0]            exe_visu,
    input  logic [31:0]            mem_visu,
    input  logic [31:0]            mpix_visu,
    input  logic [31:0]            wb_visu,
    output logic                   halt,
    pda_trace_capture_if.master    host,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int NW = 7;
`else
    localparam int NW = 6;
`endif
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL_CNT = DEPTH[AW:0];
    localparam logic [16:0]  LIMIT    = CYCLE_LIMIT[16:0];
    localparam logic [2:0]   LAST_IDX = 3'(NW - 1);

    typedef logic [NW-1:0][31:0] rec_t;
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [16:0]     cycle_cnt_q, cycle_cnt_d;
    logic            halt_q, halt_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    rec_t            mem_q [DEPTH];
    rec_t            mem_d [DEPTH];

    rec_t            rec_in;
    logic            run_cycle;
    logic            full;
    logic            is_last;
    logic            pop;
    logic            push;
    logic            drop;
    logic            sending;

    always_comb begin
        rec_in = '0;
`ifdef TRACE_TIMESTAMP_EN
        // Stamp is the count before this cycle's increment, so the first record reads 0.
        rec_in[0] = {15'b0, cycle_cnt_q};
        rec_in[1] = inst;
        rec_in[2] = deco_visu;
        rec_in[3] = exe_visu;
        rec_in[4] = mem_visu;
        rec_in[5] = mpix_visu;
        rec_in[6] = wb_visu;
`else
        rec_in[0] = inst;
        rec_in[1] = deco_visu;
        rec_in[2] = exe_visu;
        rec_in[3] = mem_visu;
        rec_in[4] = mpix_visu;
        rec_in[5] = wb_visu;
`endif
    end

    assign sending   = (state_q == ST_SEND);
    assign is_last   = (idx_q == LAST_IDX);
    assign run_cycle = run_en & ~halt_q;
    assign full      = (count_q == FULL_CNT);
    assign pop       = sending & host.out_ready & is_last;
    // A full FIFO still takes the new record when the head leaves on the same edge.
    assign push      = run_cycle & (~full | pop);
    assign drop      = run_cycle & full & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rec_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        cycle_cnt_d = run_cycle ? cycle_cnt_q + 17'd1 : cycle_cnt_q;
        halt_d      = halt_q;
        if ((CYCLE_LIMIT != 0) && run_cycle && (cycle_cnt_d == LIMIT)) begin
            halt_d = 1'b1;
        end
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (host.out_ready) begin
                    if (!is_last) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        // Count after this edge's pop/push decides whether the next record follows directly.
                        idx_d   = '0;
                        state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cycle_cnt_q <= '0;
            halt_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_q      <= halt_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Record storage needs no reset: only slots between the pointers are ever presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign host.out_valid = sending;
    assign host.out_data  = sending ? mem_q[rd_ptr_q][idx_q] : 32'd0;
    assign host.out_idx   = sending ? idx_q : 3'd0;
    assign host.out_last  = sending & is_last;
    assign halt           = halt_q;
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
